// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter slice: FSM encoding,
// default start timeout and an index-width helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XMIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_START_TIMEOUT = 64;

  // Width of an index into n lanes; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker: the first set req bit at or above
// rr_ptr, wrapping modulo NUM_REQ, as a one-hot grant plus its index.
module uart_rr_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx,
  output logic               gnt_valid
);

  logic [IW-1:0] sel;

  // Walk lanes starting at rr_ptr; the first requesting lane wins.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    sel       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!gnt_valid && req[sel]) begin
        gnt_valid = 1'b1;
        gnt_idx   = sel;
        gnt[sel]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ requesters. A winner's byte and
// parity settings are latched on grant and held until the next grant; the
// FSM then waits for the transmitter to go busy and idle again.
//
// Handshake: req is a level held by a requester until it sees its grant
// pulse, and dropped the cycle after; req is only looked at in IDLE.
// tx_en is held high until busy is sampled high (or the start timeout
// expires), and the frame is considered finished when busy is sampled low
// in XMIT.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT
) (
  input  logic                          tx_clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_parity_en,
  input  logic [NUM_REQ-1:0]            req_parity_type,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            complete,
  output logic                          timeout_err,
  output logic                          tx_en,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic                          parity_en,
  output logic                          odd_r_even_parity,
  input  logic                          busy,
  output state_t                        state_dbg
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int CW = $clog2(START_TIMEOUT + 1);

  state_t               state, state_next;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        owner;
  logic [CW-1:0]        cnt;
  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_valid;
  logic                 do_grant;
  logic                 do_started;
  logic                 do_timeout;
  logic                 do_xmit_end;
  logic                 do_done;
  logic [IW-1:0]        owner_next_ptr;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  assign state_dbg      = state;
  assign owner_next_ptr = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  // Next-state logic and the per-edge event strobes that drive the datapath.
  always_comb begin
    state_next  = state;
    do_grant    = 1'b0;
    do_started  = 1'b0;
    do_timeout  = 1'b0;
    do_xmit_end = 1'b0;
    do_done     = 1'b0;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          do_grant   = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (busy) begin
          do_started = 1'b1;
          state_next = XMIT;
        end else if (cnt == CW'(START_TIMEOUT - 1)) begin
          do_timeout = 1'b1;
          state_next = IDLE;
        end
      end
      XMIT: begin
        if (!busy) begin
          do_xmit_end = 1'b1;
          state_next  = DONE;
        end
      end
      DONE: begin
        do_done    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge tx_clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Latched transmitter lanes, pulses, round-robin pointer and start counter.
  always_ff @(posedge tx_clk or negedge rst) begin
    if (!rst) begin
      grant             <= '0;
      complete          <= '0;
      timeout_err       <= 1'b0;
      tx_en             <= 1'b0;
      data_in           <= '0;
      parity_en         <= 1'b0;
      odd_r_even_parity <= 1'b0;
      owner             <= '0;
      rr_ptr            <= '0;
      cnt               <= '0;
    end else begin
      grant       <= do_grant ? arb_gnt : '0;
      complete    <= do_xmit_end ? (NUM_REQ'(1) << owner) : '0;
      timeout_err <= do_timeout;

      if (do_grant)                      tx_en <= 1'b1;
      else if (do_started || do_timeout) tx_en <= 1'b0;

      if (do_grant) begin
        owner             <= arb_idx;
        data_in           <= req_data[arb_idx*DATA_WIDTH +: DATA_WIDTH];
        parity_en         <= req_parity_en[arb_idx];
        odd_r_even_parity <= req_parity_type[arb_idx];
      end

      // Advance past the owner whether its frame finished or never started.
      if (do_done || do_timeout) rr_ptr <= owner_next_ptr;

      if (do_grant)
        cnt <= '0;
      else if (state == START && !busy && cnt != CW'(START_TIMEOUT))
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one UART transmitter.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: byte width passed to the transmitter.
REQ-003 SHALL have parameter START_TIMEOUT, default 64: max tx_clk cycles in START waiting for busy to rise.
REQ-004 SHALL have port tx_clk, input, 1: the single clock. Rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port req, input, NUM_REQ: per-requester transmit request, level, held until grant.
REQ-007 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH: packed bytes, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_parity_en, input, NUM_REQ: per-requester parity enable.
REQ-009 SHALL have port req_parity_type, input, NUM_REQ: per-requester parity type, 0 odd, 1 even.
REQ-010 SHALL have port grant, output, NUM_REQ: one-hot, one-cycle pulse when requester's byte is latched.
REQ-011 SHALL have port complete, output, NUM_REQ: one-hot, one-cycle pulse when that requester's frame finishes.
REQ-012 SHALL have port timeout_err, output, 1: one-cycle pulse when the transmitter fails to start.
REQ-013 SHALL have port tx_en, output, 1: transmit enable to the UART transmitter.
REQ-014 SHALL have port data_in, output, DATA_WIDTH: byte to the transmitter.
REQ-015 SHALL have port parity_en, output, 1: parity enable to the transmitter.
REQ-016 SHALL have port odd_r_even_parity, output, 1: parity type to the transmitter.
REQ-017 SHALL have port busy, input, 1: transmitter busy flag.

Function
REQ-018 SHALL implement FSM states IDLE, START, XMIT, DONE; reset state IDLE.
REQ-019 IDLE, any req set: next edge -> START. Winner is the first set req bit at or above rr_ptr, wrapping modulo NUM_REQ. Same edge pulses grant[winner]. Same edge latches data_in, parity_en and odd_r_even_parity from the winner's lanes. Same edge sets tx_en=1.
REQ-020 Request-to-tx_en latency SHALL be exactly 1 cycle. Requester SHALL drop req the cycle after grant. req sampled in any non-IDLE state SHALL be ignored.
REQ-021 START: tx_en held at 1 until busy=1 is sampled. Then next edge: tx_en=0, state -> XMIT.
REQ-022 START: if busy stays 0 for START_TIMEOUT cycles, next edge: tx_en=0, timeout_err pulses, rr_ptr advances, state -> IDLE. No complete pulse is issued.
REQ-023 XMIT: on busy=0 sampled, next edge -> DONE.
REQ-024 DONE: complete[owner] pulses for one cycle, rr_ptr = (owner+1) mod NUM_REQ, next edge -> IDLE. Minimum back-to-back spacing between grants SHALL be 1 idle cycle.
REQ-025 data_in, parity_en and odd_r_even_parity SHALL hold their latched values from grant until the next grant.
REQ-026 Simultaneous requests SHALL be served round-robin. No requester waits more than NUM_REQ-1 frames.
REQ-027 The timeout counter SHALL be clog2(START_TIMEOUT+1) bits, cleared on entry to START, saturating.

Reset
REQ-028 rst low SHALL immediately force: state IDLE, rr_ptr 0, tx_en 0, grant 0, complete 0, timeout_err 0, data_in 0, parity_en 0, odd_r_even_parity 0, counter 0. This applies mid-frame, with no pending pulses after release.
REQ-029 After rst rises, the first arbitration SHALL occur no earlier than the first rising edge of tx_clk.

Structure
REQ-030 State encodings and the default START_TIMEOUT SHALL live in shared package uart_pkg.
REQ-031 Round-robin selection SHALL be the sub-module uart_rr_arbiter: req plus rr_ptr in, one-hot grant plus index out, combinational.
REQ-032 The block SHALL be instantiable alongside the existing UART top, driving its tx_en, data_in, parity_en and odd_r_even_parity and observing its busy.

Verification
REQ-033 Single request: req[2]=1, req_data lane2=8'd40, parity even. Expect grant[2] 1 cycle later, tx_en=1, data_in=40. After the loopback frame, complete[2] fires and rx data_out=40 with no errors.
REQ-034 All four requesting at once with bytes 10/20/30/40, rr_ptr=0. Expect grants in order 0,1,2,3 and received bytes 10,20,30,40.
REQ-035 Fairness: after serving 1, req[1] and req[3] both high. Expect grant[3] first, then grant[1].
REQ-036 Timeout: busy tied 0. Expect tx_en high for exactly START_TIMEOUT cycles, timeout_err pulse, return to IDLE, no complete.
REQ-037 Reset mid-XMIT: rst low for 3 cycles. Expect tx_en=0 and all outputs 0 immediately, then correct service of a new req=4'b0001 after release.
REQ-038 Mixed parity: lane0 8'd85 odd, lane1 8'd123 no parity. Expect parity_en/odd_r_even_parity to follow each grant, and both frames received with parity_error=0.
